// File: rtl/lc3_alu_pkg.sv
// lc3_alu_pkg: shared definitions for the LC3 ALU extension datapath.
// Holds the divider state encoding, the divide-by-zero quotient pattern
// and the default operand width used by the ALU extension blocks.
package lc3_alu_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // Widest operand the all-ones divide-by-zero pattern can serve.
  localparam int MAX_WIDTH = 64;

  // Quotient reported on divide-by-zero; sliced down to the operand width.
  localparam logic [MAX_WIDTH-1:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/lc3_div_step.sv
// lc3_div_step: one combinational restoring-division step.
// Shifts {R,Q} left by one, trial-subtracts the divisor from R and keeps
// the difference (setting the new quotient bit) only when it did not borrow.
module lc3_div_step
  import lc3_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   r_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH+1:0] r_shift;
  logic [WIDTH+1:0] trial;

  // Shift, trial-subtract, and restore when the subtraction borrows.
  always_comb begin
    r_shift = {r_in, q_in[WIDTH-1]};
    trial   = r_shift - {2'b00, d};
    if (trial[WIDTH+1]) begin
      r_out = r_shift[WIDTH:0];
      q_out = {q_in[WIDTH-2:0], 1'b0};
    end else begin
      r_out = trial[WIDTH:0];
      q_out = {q_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/lc3_div_seq.sv
// lc3_div_seq: iterative restoring divider for the LC3 ALU extension.
// Operands are captured on an accepted start, WIDTH restoring steps run one
// per cycle, and quotient/remainder are written on the edge entering DONE.
// done is a registered pulse one cycle after DONE is entered.
// Optional feature macro: DIV_SIGNED_EN (two's complement operands, Co flag).
module lc3_div_seq
  import lc3_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic             Co
);

  div_state_t       state;
  div_state_t       state_next;
  logic             accept;
  logic             div_zero;
  logic             last_iter;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] q_acc;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH:0]   step_r;
  logic [WIDTH-1:0] step_q;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  assign div_zero  = (num2 == '0);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign busy      = (state == S_CALC);

  lc3_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r_in  (r_acc),
    .q_in  (q_acc),
    .d     (d_reg),
    .r_out (step_r),
    .q_out (step_q)
  );

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;
  logic co_q;
  logic co_fix;

  // Feed magnitudes to the unsigned core and sign-correct the final step's result.
  always_comb begin
    a_mag    = num1[WIDTH-1] ? -num1 : num1;
    b_mag    = num2[WIDTH-1] ? -num2 : num2;
    quot_fix = neg_q ? -step_q : step_q;
    rem_fix  = neg_r ? -step_r[WIDTH-1:0] : step_r[WIDTH-1:0];
    co_fix   = ~neg_q & step_q[WIDTH-1];
  end

  // Result signs are remembered at capture; the overflow flag is written with the results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      co_q  <= 1'b0;
    end else if (accept) begin
      neg_q <= num1[WIDTH-1] ^ num2[WIDTH-1];
      neg_r <= num1[WIDTH-1];
      if (div_zero) begin
        co_q <= 1'b0;
      end
    end else if (state == S_CALC && last_iter) begin
      co_q <= co_fix;
    end
  end

  assign Co = co_q;
`else
  // Unsigned build: operands and results pass straight through the core.
  always_comb begin
    a_mag    = num1;
    b_mag    = num2;
    quot_fix = step_q;
    rem_fix  = step_r[WIDTH-1:0];
  end

  assign Co = 1'b0;
`endif

  // State register; reset drops any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: start is honoured only in IDLE or DONE, and a zero divisor skips CALC.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: accept = start;
      S_CALC: if (last_iter) state_next = S_DONE;
      S_DONE: begin
        accept     = start;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (accept) begin
      state_next = div_zero ? S_DONE : S_CALC;
    end
  end

  // Datapath: capture on accept, one restoring step per CALC cycle, results on entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      r_acc <= '0;
      q_acc <= '0;
      d_reg <= '0;
      quot  <= '0;
      rem   <= '0;
      dz    <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      if (accept) begin
        cnt   <= '0;
        r_acc <= '0;
        q_acc <= a_mag;
        d_reg <= b_mag;
        if (div_zero) begin
          quot <= DIV_ZERO_QUOT[WIDTH-1:0];
          rem  <= num1;
          dz   <= 1'b1;
        end
      end else if (state == S_CALC) begin
        cnt   <= cnt + CNT_W'(1);
        r_acc <= step_r;
        q_acc <= step_q;
        if (last_iter) begin
          quot <= quot_fix;
          rem  <= rem_fix;
          dz   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lc3_div_seq.sv
// tb_lc3_div_seq: self-checking bench for lc3_div_seq (WIDTH=16).
// A timeline model predicts every output each cycle from the accepted
// operations; directed cases pin known quotients, remainders and latencies.
// Define DIV_SIGNED_EN to exercise the signed build.
module tb_lc3_div_seq;

  localparam int W   = 16;
  localparam int LAT = W + 1;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] num1  = '0;
  logic [W-1:0] num2  = '0;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         busy;
  logic         done;
  logic         dz;
  logic         Co;

  int checks = 0;
  int passes = 0;

  lc3_div_seq #(
    .WIDTH (W),
    .CNT_W (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .num1  (num1),
    .num2  (num2),
    .quot  (quot),
    .rem   (rem),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .Co    (Co)
  );

  always #5 clk = ~clk;

  // Single comparison point shared by the directed and per-cycle checks.
  function automatic void check_output(input string name, input logic [31:0] act,
                                       input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endfunction

  // Reference division from the arithmetic definition.
  function automatic void model_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z, output logic c);
    z = 1'b0;
    c = 1'b0;
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      int sa;
      int sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sa == -(2 ** (W - 1)) && sb == -1) begin
        q = {1'b1, {(W-1){1'b0}}};
        r = '0;
        c = 1'b1;
      end else begin
        q = W'(sa / sb);
        r = W'(sa % sb);
      end
`else
      q = a / b;
      r = a % b;
`endif
    end
  endfunction

  // Timeline model state: edge index, pending result and expected outputs.
  int           e_idx     = 0;
  int           free_at   = 0;
  int           done_edge = -1;
  int           busy_lo   = 1;
  int           busy_hi   = 0;
  int           pend_upd  = 0;
  bit           pend      = 1'b0;
  logic [W-1:0] pq, pr;
  logic         pz, pc;
  logic [W-1:0] exp_quot  = '0;
  logic [W-1:0] exp_rem   = '0;
  logic         exp_dz    = 1'b0;
  logic         exp_co    = 1'b0;
  logic         exp_done  = 1'b0;
  logic         exp_busy  = 1'b0;
  logic         prev_start = 1'b0;
  logic         prev_rst   = 1'b0;
  logic [W-1:0] prev_n1    = '0;
  logic [W-1:0] prev_n2    = '0;

  // Advance the model over the last rising edge, then compare every output.
  initial begin
    forever begin
      @(negedge clk);
      e_idx++;
      if (prev_rst) begin
        if (pend && pend_upd == e_idx) begin
          exp_quot = pq; exp_rem = pr; exp_dz = pz; exp_co = pc;
          pend = 1'b0;
        end
        exp_done = (e_idx == done_edge);
        if (prev_start && e_idx >= free_at) begin
          model_div(prev_n1, prev_n2, pq, pr, pz, pc);
          if (pz) begin
            exp_quot = pq; exp_rem = pr; exp_dz = pz; exp_co = pc;
            done_edge = e_idx + 1;
            free_at   = e_idx + 1;
          end else begin
            pend      = 1'b1;
            pend_upd  = e_idx + W;
            done_edge = e_idx + W + 1;
            free_at   = e_idx + W + 1;
            busy_lo   = e_idx;
            busy_hi   = e_idx + W - 1;
          end
        end
        exp_busy = (e_idx >= busy_lo) && (e_idx <= busy_hi);
      end
      if (!rst_n) begin
        pend = 1'b0; done_edge = -1; free_at = 0; busy_lo = 1; busy_hi = 0;
        exp_quot = '0; exp_rem = '0; exp_dz = 1'b0; exp_co = 1'b0;
        exp_done = 1'b0; exp_busy = 1'b0;
      end
      check_output("cyc_quot", quot, exp_quot);
      check_output("cyc_rem",  rem,  exp_rem);
      check_output("cyc_dz",   dz,   exp_dz);
      check_output("cyc_co",   Co,   exp_co);
      check_output("cyc_done", done, exp_done);
      check_output("cyc_busy", busy, exp_busy);
      prev_start = start;
      prev_rst   = rst_n;
      prev_n1    = num1;
      prev_n2    = num2;
    end
  end

  // Wait for done, counting edges; optionally pulse start once while the divider is busy.
  task automatic wait_done(input int glitch, output int k_done);
    k_done = -1;
    for (int k = 0; k <= 40 && k_done < 0; k++) begin
      @(negedge clk);
      if (done) begin
        k_done = k;
      end else begin
        @(posedge clk);
        #1;
        if (glitch >= 0 && k == glitch) begin
          start = 1'b1; num1 = W'($urandom); num2 = W'($urandom);
        end else if (glitch >= 0 && k == glitch + 1) begin
          start = 1'b0;
        end
      end
    end
    if (k_done < 0) check_output("done_timeout", done, 1);
  endtask

  // One start/done transaction; operands are scrambled right after capture.
  task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b, input int glitch,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z, output logic c, output int lat);
    @(posedge clk);
    #1;
    start = 1'b1; num1 = a; num2 = b;
    @(posedge clk);
    #1;
    start = 1'b0; num1 = W'($urandom); num2 = W'($urandom);
    wait_done(glitch, lat);
    q = quot; r = rem; z = dz; c = Co;
  endtask

  logic [W-1:0] q, r;
  logic         z, c;
  int           lat, lat_b, done_seen;
  logic [W-1:0] ra, rb;
  int           sel, g;

  // Directed cases first, then randomized traffic.
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_quot", quot, 0);
    check_output("rst_rem",  rem,  0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_dz",   dz,   0);
    check_output("rst_co",   Co,   0);
    rst_n = 1'b1;

    apply_stimulus(16'd100, 16'd7, -1, q, r, z, c, lat);
    check_output("t1_quot", q, 14);
    check_output("t1_rem",  r, 2);
    check_output("t1_dz",   z, 0);
    check_output("t1_lat",  lat, LAT);

    apply_stimulus(16'hFFFF, 16'd1, -1, q, r, z, c, lat);
    check_output("t2a_quot", q, 16'hFFFF);
    check_output("t2a_rem",  r, 0);
    apply_stimulus(16'd3, 16'hFFFF, -1, q, r, z, c, lat);
`ifdef DIV_SIGNED_EN
    check_output("t2b_quot", q, 16'hFFFD);
    check_output("t2b_rem",  r, 0);
`else
    check_output("t2b_quot", q, 0);
    check_output("t2b_rem",  r, 3);
`endif

    apply_stimulus(16'd5, 16'd0, -1, q, r, z, c, lat);
    check_output("t3_dz",   z, 1);
    check_output("t3_quot", q, 16'hFFFF);
    check_output("t3_rem",  r, 5);
    check_output("t3_co",   c, 0);
    check_output("t3_lat",  lat, 1);

    apply_stimulus(16'd100, 16'd7, 5, q, r, z, c, lat);
    check_output("t4_quot", q, 14);
    check_output("t4_rem",  r, 2);
    check_output("t4_lat",  lat, LAT);

    // Back-to-back: start held through DONE launches the second divide at once.
    @(posedge clk);
    #1;
    start = 1'b1; num1 = 16'd50; num2 = 16'd5;
    @(posedge clk);
    #1;
    num1 = 16'd1000; num2 = 16'd33;
    wait_done(-1, lat);
    check_output("b2b_a_quot", quot, 10);
    check_output("b2b_a_rem",  rem,  0);
    check_output("b2b_a_lat",  lat,  LAT);
    check_output("b2b_busy",   busy, 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(-1, lat_b);
    check_output("b2b_b_quot", quot, 30);
    check_output("b2b_b_rem",  rem,  10);
    check_output("b2b_b_lat",  lat_b + 1, LAT);

    // Reset in the middle of a divide.
    @(posedge clk);
    #1;
    start = 1'b1; num1 = 16'd100; num2 = 16'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_output("t5_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check_output("t5_quot", quot, 0);
    check_output("t5_rem",  rem,  0);
    check_output("t5_busy", busy, 0);
    check_output("t5_done", done, 0);
    check_output("t5_dz",   dz,   0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    done_seen = 0;
    repeat (25) begin
      @(negedge clk);
      done_seen += int'(done);
    end
    check_output("t5_no_done", done_seen, 0);
    apply_stimulus(16'd100, 16'd7, -1, q, r, z, c, lat);
    check_output("t5_after_quot", q, 14);
    check_output("t5_after_rem",  r, 2);

`ifdef DIV_SIGNED_EN
    apply_stimulus(16'hFFF9, 16'd2, -1, q, r, z, c, lat);
    check_output("s1_quot", q, 16'hFFFD);
    check_output("s1_rem",  r, 16'hFFFF);
    apply_stimulus(16'h8000, 16'hFFFF, -1, q, r, z, c, lat);
    check_output("s2_quot", q, 16'h8000);
    check_output("s2_rem",  r, 0);
    check_output("s2_co",   c, 1);
    check_output("s2_lat",  lat, LAT);
    apply_stimulus(16'd7, 16'hFFFE, -1, q, r, z, c, lat);
    check_output("s3_quot", q, 16'hFFFD);
    check_output("s3_rem",  r, 1);
    check_output("s3_co",   c, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 9));
      ra  = (sel == 9) ? 16'h8000 : W'($urandom);
      if (sel == 0)      rb = '0;
      else if (sel <= 3) rb = W'($urandom_range(1, 15));
      else if (sel == 9) rb = 16'hFFFF;
      else               rb = W'($urandom);
      g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 3)) : -1;
      apply_stimulus(ra, rb, g, q, r, z, c, lat);
      check_output("rnd_lat", lat, (rb == '0) ? 1 : LAT);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Last-resort bound on simulated time.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
